// File: rtl/softmax_sequencer_pkg.sv
// Shared definitions for the pseudo-softmax sequencer: FSM encoding and default geometry.
package softmax_pkg;
    localparam int NUM_INPUTS_DEF = 10;
    localparam int MANT_WIDTH_DEF = 8;
    localparam int EXP_WIDTH_DEF  = 9;
    localparam int IDX_W          = $clog2(NUM_INPUTS_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        EMIT = 2'd3
    } state_t;
endpackage

// File: rtl/softmax_sequencer_subtractors.sv
// Lane-parallel subtraction of the log-sum estimate from every logit of the vector.
module subtractors_array
    import softmax_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int MANT_WIDTH = MANT_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF
) (
    input  logic [NUM_INPUTS-1:0][MANT_WIDTH-1:0] input_bus,
    input  logic [EXP_WIDTH-1:0]                  exp_sum,
    output logic [NUM_INPUTS-1:0][EXP_WIDTH-1:0]  exp_out
);
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        // Modulo-2^EXP_WIDTH difference; non-positive whenever exp_sum is the vector maximum.
        assign exp_out[i] = {{(EXP_WIDTH-MANT_WIDTH){1'b0}}, input_bus[i]} - exp_sum;
    end
endmodule

// File: rtl/softmax_sequencer.sv
// Collects one logit vector, tracks its maximum, then streams x[i]-max out one beat at a time.
module softmax_sequencer
    import softmax_pkg::*;
#(
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int MANT_WIDTH = MANT_WIDTH_DEF,
    parameter int EXP_WIDTH  = EXP_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  out_data,
    output logic                  out_last,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_INPUTS);

    state_t                                state, state_nx;
    logic [IW-1:0]                         idx;
    logic [MANT_WIDTH-1:0]                 max_q;
    logic [NUM_INPUTS-1:0][MANT_WIDTH-1:0] bank;
    logic [NUM_INPUTS-1:0][EXP_WIDTH-1:0]  result, exp_out;
    logic                                  in_hs, out_hs, last_idx;

    assign last_idx = (idx == IW'(NUM_INPUTS-1));
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    subtractors_array #(
        .NUM_INPUTS (NUM_INPUTS),
        .MANT_WIDTH (MANT_WIDTH),
        .EXP_WIDTH  (EXP_WIDTH)
    ) u_sub (
        .input_bus (bank),
        .exp_sum   ({1'b0, max_q}),
        .exp_out   (exp_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            max_q  <= '0;
            result <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    idx   <= '0;
                    max_q <= '0;
                end
                LOAD: if (in_hs) begin
                    // First element seeds the maximum so stale vectors never leak in.
                    max_q <= (idx == '0 || in_data > max_q) ? in_data : max_q;
                    idx   <= last_idx ? '0 : idx + IW'(1);
                end
                CALC: result <= exp_out;
                EMIT: if (out_hs) idx <= last_idx ? '0 : idx + IW'(1);
                default: ;
            endcase
        end
    end

    // Logit storage needs no reset: every entry is rewritten before CALC reads it.
    always_ff @(posedge clk) begin
        if (rst_n && in_hs) bank[idx] <= in_data;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: state_nx = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_idx) state_nx = CALC;
            end
            CALC: state_nx = EMIT;
            EMIT: begin
                out_valid = 1'b1;
                out_data  = result[idx];
                out_last  = last_idx;
                if (out_ready && last_idx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_softmax_sequencer.sv
// Directed bench for softmax_sequencer with an expected-result queue and a per-cycle monitor.
module tb_softmax_sequencer;
    localparam int NI = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_data;
    logic       out_last;
    logic       busy;

    softmax_sequencer #(.NUM_INPUTS(NI), .MANT_WIDTH(8), .EXP_WIDTH(9)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [8:0] d; logic l; } beat_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_hs = -100;
    bit         rand_rdy = 1'b0;
    beat_t      exp_q[$];
    logic [8:0] rx_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: reset values, no-overlap, stall stability, latency and beat-by-beat results.
    bit         rst_prev_low = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    logic [8:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            if (rst_prev_low) begin
                check("rst_in_ready", in_ready, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_last", out_last, 0);
            end
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_last", out_last, prev_last);
            end
            if (out_valid) begin
                check("no_overlap_in_ready", in_ready, 0);
                check("busy_in_emit", busy, 1);
            end
            if (out_valid && !prev_valid) check("first_out_latency", cyc, last_hs + 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", out_last, e.l);
                end
                rx_q.push_back(out_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_last  = out_last;
        end
        rst_prev_low = !rst_n;
    end

    // Offers n elements of v; a complete vector queues its expected results.
    task automatic send_vec(input logic [7:0] v [NI], input int n);
        int m;
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            in_valid = 1'b1;
            in_data  = v[i];
            while (!in_ready && w < 200) begin
                @(posedge clk); #1;
                w++;
            end
            if (!in_ready) begin
                check("send_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            last_hs = cyc;
        end
        in_valid = 1'b0;
        if (n == NI) begin
            m = 0;
            for (int i = 0; i < NI; i++) if (int'(v[i]) > m) m = int'(v[i]);
            for (int i = 0; i < NI; i++) begin
                beat_t e;
                int    d;
                d   = int'(v[i]) - m;
                e.d = d[8:0];
                e.l = (i == NI-1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [7:0] v [NI];
    logic [7:0] v2 [NI];

    initial begin
        // Reset held three cycles while a logit is offered.
        in_valid = 1'b1;
        in_data  = 8'h55;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Ascending ramp.
        for (int i = 0; i < NI; i++) v[i] = 8'(i);
        rx_q.delete();
        send_vec(v, NI);
        wait_drain();
        check("ramp_count", rx_q.size(), 10);
        if (rx_q.size() == 10) begin
            check("ramp_first", rx_q[0], 9'h1F7);
            check("ramp_ninth", rx_q[8], 9'h1FF);
            check("ramp_last", rx_q[9], 9'h000);
        end

        // All-max and all-zero vectors.
        for (int i = 0; i < NI; i++) v[i] = 8'hFF;
        rx_q.delete();
        send_vec(v, NI);
        wait_drain();
        check("ff_count", rx_q.size(), 10);
        if (rx_q.size() == 10) check("ff_elem0", rx_q[0], 9'h000);
        for (int i = 0; i < NI; i++) v[i] = 8'h00;
        rx_q.delete();
        send_vec(v, NI);
        wait_drain();
        check("zero_count", rx_q.size(), 10);
        if (rx_q.size() == 10) check("zero_elem4", rx_q[4], 9'h000);

        // Single spike at element 0.
        for (int i = 0; i < NI; i++) v[i] = 8'h00;
        v[0] = 8'd255;
        rx_q.delete();
        send_vec(v, NI);
        wait_drain();
        check("spike_count", rx_q.size(), 10);
        if (rx_q.size() == 10) begin
            check("spike_elem0", rx_q[0], 9'h000);
            check("spike_elem1", rx_q[1], 9'h101);
            check("spike_elem9", rx_q[9], 9'h101);
        end

        // Random back-pressure; second vector offered while the first is still emitting.
        v = '{8'd3, 8'd7, 8'd1, 8'd200, 8'd50, 8'd6, 8'd5, 8'd4, 8'd2, 8'd0};
        for (int i = 0; i < NI; i++) v2[i] = 8'(10 * (i + 1));
        rx_q.delete();
        rand_rdy = 1'b1;
        send_vec(v, NI);
        send_vec(v2, NI);
        wait_drain();
        rand_rdy = 1'b0;
        check("bp_count", rx_q.size(), 20);
        if (rx_q.size() == 20) begin
            check("bp_a0", rx_q[0], 9'h13B);
            check("bp_a3", rx_q[3], 9'h000);
            check("bp_b0", rx_q[10], 9'h1A6);
            check("bp_b9", rx_q[19], 9'h000);
        end

        // Reset after five beats discards the partial vector.
        for (int i = 0; i < NI; i++) v[i] = 8'd100;
        rx_q.delete();
        send_vec(v, 5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_no_output", rx_q.size(), 0);
        v = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6, 8'd0};
        send_vec(v, NI);
        wait_drain();
        check("post_rst_count", rx_q.size(), 10);
        if (rx_q.size() == 10) begin
            check("post_rst_elem5", rx_q[5], 9'h000);
            check("post_rst_elem9", rx_q[9], 9'h1F7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
